ma_crossover_detector: RTL and testbench
========================================

# ma_crossover_detector

Consumes a fast and a slow moving average from two upstream `moving_average` stages and turns their difference into debounced trend events (BULL / BEAR / NEUTRAL). It sits between the averaging stages and the strategy/order logic. A valid/ready handshake and a one-entry event buffer decouple it from a stalled consumer.

## Interface
- `DataWidth`, 16: width of both signed average inputs.
- `Threshold`, 8: hysteresis entry threshold, unsigned, less than 2^(DataWidth-1).
- `HoldCount`, 2: consecutive qualifying samples required to commit a transition, ≥1.
- `WarmupSamples`, 8: valid samples ignored after reset (set to slow window N), ≥1.
- `clk`, in, 1: clock.
- `reset`, in, 1: already decided as one clock; reset is synchronous and active-high.
- `avg_valid`, in, 1: `fast_avg` and `slow_avg` hold a new, aligned sample this cycle.
- `fast_avg`, in, DataWidth: signed fast moving average.
- `slow_avg`, in, DataWidth: signed slow moving average.
- `sig_valid`, out, 1: event available.
- `sig_ready`, in, 1: consumer accepts the event.
- `sig_dir`, out, 2: event direction; 2'b01 BULL, 2'b10 BEAR, 2'b00 NEUTRAL.
- `sig_diff`, out, DataWidth+1: signed diff of the sample that committed the event.
- `trend_state`, out, 2: current committed state.
- `dropped_count`, out, 8: saturating count of overwritten events.

## Operation
- `diff = fast_avg - slow_avg`. Both operands are sign-extended to DataWidth+1 first, so the result cannot overflow. Compare against `+Threshold` and `-Threshold` at DataWidth+1.
- States: WARMUP, NEUTRAL, BULL, BEAR.
- WARMUP: count valid samples. When the WarmupSamples-th sample is taken, go to NEUTRAL. No event is emitted.
- Target state per valid sample, from current state:
  - NEUTRAL: `diff > Threshold` → BULL; `diff < -Threshold` → BEAR; otherwise NEUTRAL.
  - BULL: `diff < -Threshold` → BEAR; `diff <= 0` → NEUTRAL; otherwise BULL.
  - BEAR: symmetric. `diff > Threshold` → BULL; `diff >= 0` → NEUTRAL; otherwise BEAR.
- Debounce uses a candidate register and a hold counter.
  - If target equals current state, clear the counter.
  - If target differs from the candidate, load the candidate and set the counter to 1.
  - Otherwise, increment the counter.
  - When the counter reaches HoldCount, commit: state ← candidate, clear the counter, emit an event {candidate, diff}.
  - With HoldCount=1, the commit happens on the first qualifying sample.
- Cycles with `avg_valid=0` change nothing: no counter or state update.
- Event buffer holds one entry:
  - Emit while empty: load the entry.
  - Handshake `sig_valid & sig_ready`: pop the entry.
  - Emit while full and not popping: overwrite with the new event (newest wins) and increment `dropped_count`, saturating at 255.
  - Emit while popping in the same cycle: load the new event, no drop.
- Reset:
  - `trend_state` = WARMUP (2'b00), candidate = NEUTRAL, counters = 0.
  - `sig_valid` = 0, `sig_dir` = 0, `sig_diff` = 0, `dropped_count` = 0.
  - Reset mid-operation discards any pending event and restarts warm-up.

## Timing
- Single-edge registered design.
- Commit sample taken at edge k → `trend_state` updates and `sig_valid` rises after edge k, visible in cycle k+1.
- Event latency is 1 cycle. Throughput is one sample per cycle.
- `sig_valid`, `sig_dir`, `sig_diff` are registered and stay stable while `sig_valid & !sig_ready`, except on overwrite.
- No combinational path from `sig_ready` to `sig_valid`.
- `reset` takes priority over all other inputs on the same edge.

## Structure
- Shared package `ma_signal_pkg`:
  - `trend_state_t` enum: WARMUP=2'b00, BULL=2'b01, BEAR=2'b10, NEUTRAL=2'b11.
  - `sig_dir_t` encodings.
  - `trend_event_t` struct {dir, diff}, parameterised by width through a localparam in the top.
- Sub-module `trend_event_buffer`: a one-entry valid/ready holding register with overwrite and saturating drop counter.
- FSM, debounce and diff arithmetic stay in the top module.

## Test plan
Defaults for all scenarios: DataWidth=16, Threshold=8, HoldCount=2, WarmupSamples=4.
- Warm-up: 4 samples with fast=120, slow=100 → no `sig_valid`; `trend_state` = WARMUP until the 4th sample, NEUTRAL after. Next two samples with diff=20 → `sig_valid`=1, dir=01, `sig_diff`=20 one cycle after the 2nd sample.
- Hysteresis: in BULL, diff=5 ×3 → stays BULL, no event. Then diff=0 ×2 → NEUTRAL event, `sig_diff`=0. From NEUTRAL, diff=-9 ×2 → BEAR event, `sig_diff`=-9.
- Debounce break: in NEUTRAL, alternate diff 20, 0, 20, 0 → no event. A valid sample, then `avg_valid` low for 5 cycles, then a valid sample (both diff=20) → event fires, because idle cycles do not reset the count.
- Backpressure: `sig_ready`=0, force BULL then NEUTRAL commits → entry holds NEUTRAL, `dropped_count`=1. Then `sig_ready`=1 → single handshake, `sig_valid` falls. After 300 forced drops, `dropped_count`=255.
- Extremes: fast=32767, slow=-32768 → `sig_diff`=+65535 with no wrap. Reversed operands → -65535, BEAR.
- Reset mid-hold and with a pending event → all outputs return to reset values next cycle; warm-up re-requires 4 samples.

Source files
------------

// File: rtl/ma_signal_pkg.sv
// Shared trend encodings and helpers for the MA crossover detector.
// trend_state_t: committed trend; sig_dir_t: event direction on the wire.
package ma_signal_pkg;

   typedef enum logic [1:0] {
      WARMUP  = 2'b00,
      BULL    = 2'b01,
      BEAR    = 2'b10,
      NEUTRAL = 2'b11
   } trend_state_t;

   typedef enum logic [1:0] {
      DIR_NEUTRAL = 2'b00,
      DIR_BULL    = 2'b01,
      DIR_BEAR    = 2'b10
   } sig_dir_t;

   localparam int DropWidth = 8;

   // State and direction encodings differ for NEUTRAL (11 vs 00).
   function automatic sig_dir_t state_to_dir(trend_state_t s);
      sig_dir_t d;
      case (s)
         BULL:    d = DIR_BULL;
         BEAR:    d = DIR_BEAR;
         default: d = DIR_NEUTRAL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/trend_event_buffer.sv
// One-entry valid/ready event register; newest event wins when full.
// Ports: push_i/data_i load, valid_o/ready_i/data_o drain, dropped_o count.
module trend_event_buffer
   import ma_signal_pkg::*;
#(
   parameter int Width = 19
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push_i,
   input  logic [Width-1:0]     data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [Width-1:0]     data_o,
   output logic [DropWidth-1:0] dropped_o
);

   logic                 valid_q, valid_d;
   logic [Width-1:0]     data_q, data_d;
   logic [DropWidth-1:0] drop_q, drop_d;
   logic                 pop;

   assign pop = valid_q & ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      drop_d  = drop_q;
      if (push_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         // Only a push onto an entry nobody took loses data.
         if (valid_q && !pop && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
         end
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         drop_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
      end
   end

   assign valid_o   = valid_q;
   assign data_o    = data_q;
   assign dropped_o = drop_q;

endmodule

// File: rtl/ma_crossover_detector.sv
// Turns fast/slow moving-average difference into debounced trend events.
// Ports: avg_valid/fast_avg/slow_avg in; sig_* event stream, trend_state,
// dropped_count out. Event struct is sized here from DataWidth.
module ma_crossover_detector
   import ma_signal_pkg::*;
#(
   parameter int DataWidth     = 16,
   parameter int Threshold     = 8,
   parameter int HoldCount     = 2,
   parameter int WarmupSamples = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 avg_valid,
   input  logic [DataWidth-1:0] fast_avg,
   input  logic [DataWidth-1:0] slow_avg,
   output logic                 sig_valid,
   input  logic                 sig_ready,
   output logic [1:0]           sig_dir,
   output logic [DataWidth:0]   sig_diff,
   output logic [1:0]           trend_state,
   output logic [7:0]           dropped_count
);

   localparam int DiffW = DataWidth + 1;
   localparam int HoldW = $clog2(HoldCount + 1);
   localparam int WarmW = $clog2(WarmupSamples + 1);

   localparam logic signed [DiffW-1:0] ThrPos =
      DiffW'(Threshold);
   localparam logic signed [DiffW-1:0] ThrNeg = -ThrPos;
   localparam logic signed [DiffW-1:0] Zero = '0;
   localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCount);
   localparam logic [WarmW-1:0] WarmMax = WarmW'(WarmupSamples);

   typedef struct packed {
      sig_dir_t         dir;
      logic [DiffW-1:0] diff;
   } trend_event_t;

   localparam int EvW = $bits(trend_event_t);

   trend_state_t            state_q, state_d;
   trend_state_t            cand_q, cand_d;
   trend_state_t            target;
   logic [HoldW-1:0]        hold_q, hold_d;
   logic [WarmW-1:0]        warm_q, warm_d;
   logic signed [DiffW-1:0] diff;
   logic                    commit;
   trend_event_t            ev;
   trend_event_t            out_ev;
   logic [EvW-1:0]          buf_data;

   // One extra bit of headroom: the difference can never wrap.
   assign diff = $signed({fast_avg[DataWidth-1], fast_avg})
               - $signed({slow_avg[DataWidth-1], slow_avg});

   // Hysteresis: leaving a trend only needs the sign to flip,
   // entering one needs the threshold to be crossed.
   always_comb begin
      target = state_q;
      case (state_q)
         NEUTRAL: begin
            if (diff > ThrPos)      target = BULL;
            else if (diff < ThrNeg) target = BEAR;
         end
         BULL: begin
            if (diff < ThrNeg)     target = BEAR;
            else if (diff <= Zero) target = NEUTRAL;
         end
         BEAR: begin
            if (diff > ThrPos)     target = BULL;
            else if (diff >= Zero) target = NEUTRAL;
         end
         default: target = state_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      hold_d  = hold_q;
      warm_d  = warm_q;
      commit  = 1'b0;
      if (avg_valid) begin
         if (state_q == WARMUP) begin
            warm_d = warm_q + 1'b1;
            if (warm_d == WarmMax) state_d = NEUTRAL;
         end else if (target == state_q) begin
            hold_d = '0;
         end else begin
            if (target != cand_q) begin
               cand_d = target;
               hold_d = HoldW'(1);
            end else begin
               hold_d = hold_q + 1'b1;
            end
            if (hold_d == HoldMax) begin
               state_d = cand_d;
               hold_d  = '0;
               commit  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ev      = '0;
      ev.dir  = state_to_dir(cand_d);
      ev.diff = diff;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WARMUP;
         cand_q  <= NEUTRAL;
         hold_q  <= '0;
         warm_q  <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         hold_q  <= hold_d;
         warm_q  <= warm_d;
      end
   end

   trend_event_buffer #(
      .Width(EvW)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .push_i   (commit),
      .data_i   (ev),
      .valid_o  (sig_valid),
      .ready_i  (sig_ready),
      .data_o   (buf_data),
      .dropped_o(dropped_count)
   );

   assign out_ev      = trend_event_t'(buf_data);
   assign sig_dir     = out_ev.dir;
   assign sig_diff    = out_ev.diff;
   assign trend_state = state_q;

endmodule

// File: tb/tb_ma_crossover_detector.sv
// Scenario bench for ma_crossover_detector with a behavioural model.
// Directed trend scenarios followed by a randomized soak.
module tb_ma_crossover_detector;

   localparam int W = 4;
   localparam int TH = 8;
   localparam int HC = 2;
   localparam int S_WU = 0, S_BU = 1, S_BE = 2, S_NE = 3;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               avg_valid = 1'b0;
   logic signed [15:0] fast_avg = '0;
   logic signed [15:0] slow_avg = '0;
   logic               sig_valid;
   logic               sig_ready = 1'b1;
   logic [1:0]         sig_dir;
   logic [16:0]        sig_diff;
   logic [1:0]         trend_state;
   logic [7:0]         dropped_count;

   int errors = 0;
   int checks = 0;

   // model
   int m_state, m_cand, m_cnt, m_warm;
   int m_dir, m_diff, m_drop;
   bit m_valid;

   always #5 clk = ~clk;

   ma_crossover_detector #(
      .DataWidth(16),
      .Threshold(TH),
      .HoldCount(HC),
      .WarmupSamples(W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .avg_valid    (avg_valid),
      .fast_avg     (fast_avg),
      .slow_avg     (slow_avg),
      .sig_valid    (sig_valid),
      .sig_ready    (sig_ready),
      .sig_dir      (sig_dir),
      .sig_diff     (sig_diff),
      .trend_state  (trend_state),
      .dropped_count(dropped_count)
   );

   function automatic int target_of(int s, int d);
      case (s)
         S_NE: return d > TH ? S_BU : (d < -TH ? S_BE : S_NE);
         S_BU: return d < -TH ? S_BE : (d <= 0 ? S_NE : S_BU);
         S_BE: return d > TH ? S_BU : (d >= 0 ? S_NE : S_BE);
         default: return s;
      endcase
   endfunction

   function automatic int dir_of(int s);
      return s == S_BU ? 1 : (s == S_BE ? 2 : 0);
   endfunction

   task automatic model_edge();
      int d, t;
      bit pop, emit;
      if (reset) begin
         m_state = S_WU; m_cand = S_NE; m_cnt = 0; m_warm = 0;
         m_valid = 0; m_dir = 0; m_diff = 0; m_drop = 0;
         return;
      end
      pop = m_valid && sig_ready;
      emit = 0;
      d = 0;
      if (avg_valid) begin
         d = int'(fast_avg) - int'(slow_avg);
         if (m_state == S_WU) begin
            m_warm++;
            if (m_warm == W) m_state = S_NE;
         end else begin
            t = target_of(m_state, d);
            if (t == m_state) m_cnt = 0;
            else if (t != m_cand) begin m_cand = t; m_cnt = 1; end
            else m_cnt++;
            if (m_cnt == HC) begin
               m_state = m_cand; m_cnt = 0; emit = 1;
            end
         end
      end
      if (emit) begin
         if (m_valid && !pop && m_drop < 255) m_drop++;
         m_valid = 1; m_dir = dir_of(m_state); m_diff = d;
      end else if (pop) begin
         m_valid = 0;
      end
   endtask

   task automatic step(input logic v, input int f, input int s);
      avg_valid = v;
      fast_avg = f[15:0];
      slow_avg = s[15:0];
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(1'b1, 50, 0);
      step(1'b1, 50, 0);
      checks += 5;
      if (sig_valid !== 1'b0) begin errors++;
         $display("FAIL rst_valid: got %0b want 0", sig_valid); end
      if (sig_dir !== 2'b00) begin errors++;
         $display("FAIL rst_dir: got %0d want 0", sig_dir); end
      if (sig_diff !== 17'd0) begin errors++;
         $display("FAIL rst_diff: got %0d want 0", sig_diff); end
      if (trend_state !== 2'b00) begin errors++;
         $display("FAIL rst_state: got %0d want 0", trend_state); end
      if (dropped_count !== 8'd0) begin errors++;
         $display("FAIL rst_drop: got %0d want 0", dropped_count); end
      reset = 1'b0;
   endtask

   task automatic test_warmup();
      logic [1:0] exp_st;
      sig_ready = 1'b1;
      for (int i = 0; i < W; i++) begin
         step(1'b1, 120, 100);
         exp_st = (i < W - 1) ? 2'b00 : 2'b11;
         checks += 2;
         if (trend_state !== exp_st) begin errors++;
            $display("FAIL warm_state[%0d]: got %0d want %0d",
                     i, trend_state, exp_st); end
         if (sig_valid !== 1'b0) begin errors++;
            $display("FAIL warm_valid[%0d]: got %0b want 0",
                     i, sig_valid); end
      end
      step(1'b1, 20, 0);
      checks++;
      if (sig_valid !== 1'b0) begin errors++;
         $display("FAIL warm_early: got %0b want 0", sig_valid); end
      step(1'b1, 20, 0);
      checks += 4;
      if (sig_valid !== 1'b1) begin errors++;
         $display("FAIL bull_valid: got %0b want 1", sig_valid); end
      if (sig_dir !== 2'b01) begin errors++;
         $display("FAIL bull_dir: got %0d want 1", sig_dir); end
      if (sig_diff !== 17'd20) begin errors++;
         $display("FAIL bull_diff: got %0d want 20", sig_diff); end
      if (trend_state !== 2'b01) begin errors++;
         $display("FAIL bull_state: got %0d want 1", trend_state); end
   endtask

   task automatic test_hysteresis();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 5, 0);
         checks += 2;
         if (trend_state !== 2'b01) begin errors++;
            $display("FAIL hyst_hold[%0d]: got %0d want 1",
                     i, trend_state); end
         if (sig_valid !== 1'b0) begin errors++;
            $display("FAIL hyst_noev[%0d]: got %0b want 0",
                     i, sig_valid); end
      end
      step(1'b1, 0, 0);
      step(1'b1, 0, 0);
      checks += 3;
      if (sig_valid !== 1'b1 || sig_dir !== 2'b00) begin errors++;
         $display("FAIL hyst_neu: got v=%0b d=%0d want v=1 d=0",
                  sig_valid, sig_dir); end
      if (sig_diff !== 17'd0) begin errors++;
         $display("FAIL hyst_neu_diff: got %0d want 0", sig_diff); end
      if (trend_state !== 2'b11) begin errors++;
         $display("FAIL hyst_neu_st: got %0d want 3", trend_state); end
      step(1'b1, -9, 0);
      step(1'b1, -9, 0);
      checks += 3;
      if (sig_valid !== 1'b1 || sig_dir !== 2'b10) begin errors++;
         $display("FAIL hyst_bear: got v=%0b d=%0d want v=1 d=2",
                  sig_valid, sig_dir); end
      if (sig_diff !== 17'h1FFF7) begin errors++;
         $display("FAIL hyst_bear_diff: got %0h want 1fff7",
                  sig_diff); end
      if (trend_state !== 2'b10) begin errors++;
         $display("FAIL hyst_bear_st: got %0d want 2", trend_state); end
   endtask

   task automatic test_debounce();
      step(1'b1, 0, 0);
      step(1'b1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, (i % 2 == 0) ? 20 : 0, 0);
         checks++;
         if (sig_valid !== 1'b0 || trend_state !== 2'b11) begin
            errors++;
            $display("FAIL deb_alt[%0d]: got v=%0b s=%0d want 0/3",
                     i, sig_valid, trend_state); end
      end
      step(1'b1, 20, 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 20, 0);
         checks++;
         if (sig_valid !== 1'b0) begin errors++;
            $display("FAIL deb_idle[%0d]: got %0b want 0",
                     i, sig_valid); end
      end
      step(1'b1, 20, 0);
      checks++;
      if (sig_valid !== 1'b1 || sig_dir !== 2'b01) begin errors++;
         $display("FAIL deb_fire: got v=%0b d=%0d want v=1 d=1",
                  sig_valid, sig_dir); end
   endtask

   task automatic test_backpressure();
      sig_ready = 1'b1;
      step(1'b0, 0, 0);
      step(1'b1, 0, 0);
      step(1'b1, 0, 0);
      step(1'b0, 0, 0);
      sig_ready = 1'b0;
      step(1'b1, 20, 0);
      step(1'b1, 20, 0);
      step(1'b1, 0, 0);
      checks++;
      if (sig_valid !== 1'b1 || sig_dir !== 2'b01) begin errors++;
         $display("FAIL bp_stable: got v=%0b d=%0d want v=1 d=1",
                  sig_valid, sig_dir); end
      step(1'b1, 0, 0);
      checks += 2;
      if (sig_valid !== 1'b1 || sig_dir !== 2'b00) begin errors++;
         $display("FAIL bp_over: got v=%0b d=%0d want v=1 d=0",
                  sig_valid, sig_dir); end
      if (dropped_count !== 8'd1) begin errors++;
         $display("FAIL bp_drop1: got %0d want 1", dropped_count); end
      sig_ready = 1'b1;
      step(1'b0, 0, 0);
      checks++;
      if (sig_valid !== 1'b0 || dropped_count !== 8'd1) begin
         errors++;
         $display("FAIL bp_pop: got v=%0b n=%0d want v=0 n=1",
                  sig_valid, dropped_count); end
      sig_ready = 1'b0;
      for (int i = 0; i < 301; i++) begin
         step(1'b1, (i % 2 == 0) ? 20 : 0, 0);
         step(1'b1, (i % 2 == 0) ? 20 : 0, 0);
      end
      checks++;
      if (dropped_count !== 8'd255) begin errors++;
         $display("FAIL bp_sat: got %0d want 255", dropped_count); end
      sig_ready = 1'b1;
      step(1'b0, 0, 0);
   endtask

   task automatic test_extremes();
      step(1'b1, 0, 0);
      step(1'b1, 0, 0);
      step(1'b1, 32767, -32768);
      step(1'b1, 32767, -32768);
      checks += 2;
      if (sig_diff !== 17'h0FFFF) begin errors++;
         $display("FAIL ext_pos: got %0h want 0ffff", sig_diff); end
      if (sig_dir !== 2'b01) begin errors++;
         $display("FAIL ext_pos_dir: got %0d want 1", sig_dir); end
      step(1'b1, -32768, 32767);
      step(1'b1, -32768, 32767);
      checks += 2;
      if (sig_diff !== 17'h10001) begin errors++;
         $display("FAIL ext_neg: got %0h want 10001", sig_diff); end
      if (sig_dir !== 2'b10 || trend_state !== 2'b10) begin errors++;
         $display("FAIL ext_neg_dir: got d=%0d s=%0d want 2/2",
                  sig_dir, trend_state); end
   endtask

   task automatic test_reset_mid();
      sig_ready = 1'b0;
      step(1'b1, 0, 0);
      checks++;
      if (sig_valid !== 1'b1) begin errors++;
         $display("FAIL rm_pend: got %0b want 1", sig_valid); end
      reset = 1'b1;
      step(1'b1, 0, 0);
      reset = 1'b0;
      checks++;
      if (sig_valid !== 1'b0 || sig_dir !== 2'b00 ||
          sig_diff !== 17'd0 || trend_state !== 2'b00 ||
          dropped_count !== 8'd0) begin errors++;
         $display("FAIL rm_clear: got v=%0b d=%0d x=%0d s=%0d n=%0d",
                  sig_valid, sig_dir, sig_diff, trend_state,
                  dropped_count); end
      sig_ready = 1'b1;
      for (int i = 0; i < W; i++) begin
         step(1'b1, 20, 0);
         checks++;
         if (trend_state !== ((i < W - 1) ? 2'b00 : 2'b11) ||
             sig_valid !== 1'b0) begin errors++;
            $display("FAIL rm_warm[%0d]: got s=%0d v=%0b",
                     i, trend_state, sig_valid); end
      end
      step(1'b1, 20, 0);
      step(1'b1, 20, 0);
      checks++;
      if (sig_valid !== 1'b1 || sig_dir !== 2'b01) begin errors++;
         $display("FAIL rm_bull: got v=%0b d=%0d want v=1 d=1",
                  sig_valid, sig_dir); end
   endtask

   task automatic test_random();
      int s, f;
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 399) == 0);
         sig_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 49) == 0) begin
            f = int'($urandom_range(0, 65535)) - 32768;
            s = int'($urandom_range(0, 65535)) - 32768;
         end else begin
            s = int'($urandom_range(0, 2000)) - 1000;
            f = s + int'($urandom_range(0, 40)) - 20;
         end
         step($urandom_range(0, 3) != 0, f, s);
         checks += 3;
         if (sig_valid !== m_valid) begin errors++;
            $display("FAIL rnd_valid[%0d]: got %0b want %0b",
                     i, sig_valid, m_valid); end
         if (int'(trend_state) != m_state) begin errors++;
            $display("FAIL rnd_state[%0d]: got %0d want %0d",
                     i, trend_state, m_state); end
         if (int'(dropped_count) != m_drop) begin errors++;
            $display("FAIL rnd_drop[%0d]: got %0d want %0d",
                     i, dropped_count, m_drop); end
         if (m_valid) begin
            checks++;
            if (int'(sig_dir) != m_dir ||
                int'($signed(sig_diff)) != m_diff) begin errors++;
               $display("FAIL rnd_ev[%0d]: got %0d/%0d want %0d/%0d",
                        i, sig_dir, $signed(sig_diff), m_dir, m_diff);
            end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_warmup();
      test_hysteresis();
      test_debounce();
      test_backpressure();
      test_extremes();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
